disp_scan_ctrl: RTL

Time-multiplexed scan controller for the 8-digit seven-segment display. It holds one 4-bit BCD value per digit, selects one digit at a time, and drives the shared `num` bus of the BCD-to-segment decoder. Between digits it inserts a programmable blanking gap to suppress ghosting. It sits between the game/counter logic, which writes digit values, and the segment decoder plus the digit-select pins.

---
 rtl/disp_scan_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment display.
// Define DISP_LZB_EN to enable leading-zero blanking of the upper digits.
module disp_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] num,
  output logic [7:0] dig,
  output logic       frame_done
);

  localparam int unsigned NDIG    = 8;
  localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam bit          NO_GAP    = (BLANK_CYC == 0);
  localparam logic [7:0]  DIG_OFF   = 8'hFF;
  localparam logic [3:0]  NUM_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    idx_inc;
  logic [3:0]    regs     [NDIG];
  logic [3:0]    regs_nxt [NDIG];
  logic [3:0]    disp_val [NDIG];

  assign idx_inc = idx + 3'd1;

  // Digit register file; writable in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Register file as it will be after this edge, so writes bypass straight to num.
  always_comb begin
    for (int unsigned i = 0; i < NDIG; i++) begin
      regs_nxt[i] = (wr_en && (wr_addr == 3'(i))) ? wr_data : regs[i];
    end
  end

`ifdef DISP_LZB_EN
  // Zeros above the most significant nonzero digit are blanked; digit 0 always shows.
  always_comb begin
    logic lead;
    lead        = 1'b1;
    disp_val[0] = regs_nxt[0];
    for (int i = int'(NDIG) - 1; i >= 1; i--) begin
      lead        = lead && (regs_nxt[i] == 4'd0);
      disp_val[i] = lead ? NUM_BLANK : regs_nxt[i];
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NDIG; i++) begin
      disp_val[i] = regs_nxt[i];
    end
  end
`endif

  // Scan sequencer with registered digit-select, value and frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      dig        <= DIG_OFF;
      num        <= NUM_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!st) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
        dig   <= DIG_OFF;
        num   <= NUM_BLANK;
      end else begin
        case (state)
          IDLE: begin
            state <= SHOW;
            cnt   <= '0;
            idx   <= '0;
            dig   <= 8'hFE;
            num   <= disp_val[0];
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              cnt <= '0;
              if (NO_GAP) begin
                idx        <= idx_inc;
                dig        <= ~(8'b1 << idx_inc);
                num        <= disp_val[idx_inc];
                frame_done <= (idx == 3'd7);
              end else begin
                state <= GAP;
                dig   <= DIG_OFF;
                num   <= NUM_BLANK;
              end
            end else begin
              cnt <= cnt + CW'(1);
              num <= disp_val[idx];
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              state      <= SHOW;
              cnt        <= '0;
              idx        <= idx_inc;
              dig        <= ~(8'b1 << idx_inc);
              num        <= disp_val[idx_inc];
              frame_done <= (idx == 3'd7);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            dig   <= DIG_OFF;
            num   <= NUM_BLANK;
          end
        endcase
      end
    end
  end

endmodule
